// File: rtl/cpu64_div_ctrl.sv
// Front/back-end controller around an unsigned pipelined divider: operand sign
// handling, in-order metadata tracking, result fix-up and a buffered output.
module cpu64_div_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             div_req_o,
  output logic [XLEN-1:0]  div_a_o,
  output logic [XLEN-1:0]  div_b_o,
  input  logic [XLEN-1:0]  div_quotient_i,
  input  logic [XLEN-1:0]  div_remainder_i,
  input  logic             div_done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             dbz_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             rem;
    logic             word;
    logic [TAG_W-1:0] tag;
    logic             qneg;
    logic             rneg;
    logic             dbz;
    logic             ovf;
    logic [XLEN-1:0]  eff_a;
  } meta_t;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             dbz;
    logic             ovf;
  } res_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  meta_t            meta_mem_q [DEPTH];
  res_t             res_mem_q  [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] m_cnt_q, m_cnt_d, r_cnt_q, r_cnt_d;
  logic [PTR_W-1:0] m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic [PTR_W-1:0] r_wr_q, r_wr_d, r_rd_q, r_rd_d;
  logic             in_ready_q, in_ready_d;
  logic             err_q, err_d;

  logic             accept, m_pop, out_pop, is_signed, sa, sb;
  logic [XLEN-1:0]  eff_a, eff_b, min_neg, mag_a, mag_b;
  logic [XLEN-1:0]  q_fix, r_fix, sel;
  meta_t            meta_in, meta_head;
  res_t             res_in, res_head;

  // Front end: effective operands, signs and magnitudes.
  always_comb begin
    is_signed = ~op_i[0];
    accept    = in_valid_i & in_ready_q;
    if (word_i) begin
      if (is_signed) begin
        eff_a = XLEN'($signed(op_a_i[31:0]));
        eff_b = XLEN'($signed(op_b_i[31:0]));
      end else begin
        eff_a = XLEN'(op_a_i[31:0]);
        eff_b = XLEN'(op_b_i[31:0]);
      end
      min_neg = XLEN'($signed(32'h8000_0000));
    end else begin
      eff_a   = op_a_i;
      eff_b   = op_b_i;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    sa    = is_signed & eff_a[XLEN-1];
    sb    = is_signed & eff_b[XLEN-1];
    mag_a = sa ? ('0 - eff_a) : eff_a;
    mag_b = sb ? ('0 - eff_b) : eff_b;

    meta_in.rem   = op_i[1];
    meta_in.word  = word_i;
    meta_in.tag   = tag_i;
    meta_in.qneg  = sa ^ sb;
    meta_in.rneg  = sa;
    meta_in.dbz   = (eff_b == '0);
    meta_in.ovf   = is_signed && (eff_a == min_neg) && (eff_b == '1);
    meta_in.eff_a = eff_a;
  end

  // Back end: sign fix-up and special-case override of the metadata head.
  always_comb begin
    meta_head = meta_mem_q[m_rd_q];
    q_fix = meta_head.qneg ? ('0 - div_quotient_i) : div_quotient_i;
    r_fix = meta_head.rneg ? ('0 - div_remainder_i) : div_remainder_i;
    if (meta_head.dbz) begin
      q_fix = '1;
      r_fix = meta_head.eff_a;
    end
    if (meta_head.ovf) begin
      q_fix = meta_head.eff_a;
      r_fix = '0;
    end
    sel = meta_head.rem ? r_fix : q_fix;
    if (meta_head.word) begin
      sel = XLEN'($signed(sel[31:0]));
    end
    res_in.res = sel;
    res_in.tag = meta_head.tag;
    res_in.dbz = meta_head.dbz;
    res_in.ovf = meta_head.ovf;
  end

  always_comb begin
    out_pop    = (r_cnt_q != '0) && out_ready_i;
    m_pop      = div_done_i && (m_cnt_q != '0);
    m_wr_d     = accept ? ptr_inc(m_wr_q) : m_wr_q;
    m_rd_d     = m_pop ? ptr_inc(m_rd_q) : m_rd_q;
    r_wr_d     = m_pop ? ptr_inc(r_wr_q) : r_wr_q;
    r_rd_d     = out_pop ? ptr_inc(r_rd_q) : r_rd_q;
    m_cnt_d    = m_cnt_q + CNT_W'(accept) - CNT_W'(m_pop);
    r_cnt_d    = r_cnt_q + CNT_W'(m_pop) - CNT_W'(out_pop);
    count_d    = count_q + CNT_W'(accept) - CNT_W'(out_pop);
    in_ready_d = (count_d < CNT_W'(DEPTH));
    err_d      = err_q | (div_done_i && (m_cnt_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      m_cnt_q    <= '0;
      r_cnt_q    <= '0;
      m_wr_q     <= '0;
      m_rd_q     <= '0;
      r_wr_q     <= '0;
      r_rd_q     <= '0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      m_cnt_q    <= m_cnt_d;
      r_cnt_q    <= r_cnt_d;
      m_wr_q     <= m_wr_d;
      m_rd_q     <= m_rd_d;
      r_wr_q     <= r_wr_d;
      r_rd_q     <= r_rd_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: contents are only observed behind the counters.
  always_ff @(posedge clk_i) begin
    if (accept) meta_mem_q[m_wr_q] <= meta_in;
    if (m_pop)  res_mem_q[r_wr_q]  <= res_in;
  end

  always_comb begin
    res_head    = res_mem_q[r_rd_q];
    out_valid_o = (r_cnt_q != '0);
    result_o    = out_valid_o ? res_head.res : '0;
    tag_o       = out_valid_o ? res_head.tag : '0;
    dbz_o       = out_valid_o & res_head.dbz;
    ovf_o       = out_valid_o & res_head.ovf;
    in_ready_o  = in_ready_q;
    err_o       = err_q;
    div_req_o   = accept;
    div_a_o     = accept ? mag_a : '0;
    div_b_o     = accept ? mag_b : '0;
  end

endmodule

// File: tb/tb_cpu64_div_ctrl.sv
// Bench for cpu64_div_ctrl: behavioural divider pipeline plus an arithmetic
// reference model of RISC-V division semantics.
module tb_cpu64_div_ctrl;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned L     = 13;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [1:0]       op_i = '0;
  logic             word_i = 1'b0;
  logic [XLEN-1:0]  op_a_i = '0, op_b_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             div_req_o;
  logic [XLEN-1:0]  div_a_o, div_b_o, div_quotient_i, div_remainder_i;
  logic             div_done_i;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             dbz_o, ovf_o, err_o;
  logic             inj_done = 1'b0;

  always #5 clk = ~clk;

  cpu64_div_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .word_i(word_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i),
    .div_req_o(div_req_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .div_done_i(div_done_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .tag_o(tag_o), .dbz_o(dbz_o), .ovf_o(ovf_o), .err_o(err_o)
  );

  // Unsigned divider with fixed latency L, reset by the same signal.
  logic [L-1:0]    pv;
  logic [XLEN-1:0] pq [L];
  logic [XLEN-1:0] pr [L];
  always @(posedge clk) begin
    if (rst_i) begin
      pv <= '0;
    end else begin
      pv <= {pv[L-2:0], div_req_o};
      for (int i = L - 1; i > 0; i--) begin
        pq[i] <= pq[i-1];
        pr[i] <= pr[i-1];
      end
      if (div_b_o == '0) begin
        pq[0] <= '1;
        pr[0] <= div_a_o;
      end else begin
        pq[0] <= div_a_o / div_b_o;
        pr[0] <= div_a_o % div_b_o;
      end
    end
  end
  assign div_done_i      = pv[L-1] | inj_done;
  assign div_quotient_i  = pq[L-1];
  assign div_remainder_i = pr[L-1];

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             dbz;
    logic             ovf;
    int unsigned      cyc;
  } item_t;

  item_t       exp_q[$];
  item_t       obs_q[$];
  int unsigned cyc_n = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic item_t model(input logic [1:0] op, input logic word,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [TAG_W-1:0] tag);
    item_t it;
    longint sa, sb, sq, sr, mn;
    logic [63:0] ua, ub, uq, ur, sel;
    if (word) begin
      sa = longint'($signed(a[31:0]));
      sb = longint'($signed(b[31:0]));
      ua = {32'h0, a[31:0]};
      ub = {32'h0, b[31:0]};
      mn = -(longint'(1) <<< 31);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      ua = a;
      ub = b;
      mn = longint'(1) <<< 63;
    end
    it.ovf = 1'b0;
    if (!op[0]) begin
      it.dbz = (sb == 0);
      it.ovf = (sb == -1) && (sa == mn);
      if (it.dbz) begin
        sq = -1; sr = sa;
      end else if (it.ovf) begin
        sq = sa; sr = 0;
      end else begin
        sq = sa / sb; sr = sa % sb;
      end
      sel = op[1] ? 64'(sr) : 64'(sq);
    end else begin
      it.dbz = (ub == 0);
      if (it.dbz) begin
        uq = '1; ur = ua;
      end else begin
        uq = ua / ub; ur = ua % ub;
      end
      sel = op[1] ? ur : uq;
    end
    if (word) sel = {{32{sel[31]}}, sel[31:0]};
    it.res = sel;
    it.tag = tag;
    it.cyc = cyc_n;
    return it;
  endfunction

  // Records handshakes seen at the falling edge, then advances one cycle.
  task automatic tick();
    item_t o;
    @(negedge clk);
    if (in_valid_i && in_ready_o) exp_q.push_back(model(op_i, word_i, op_a_i, op_b_i, tag_i));
    if (out_valid_o && out_ready_i) begin
      o.res = result_o; o.tag = tag_o; o.dbz = dbz_o; o.ovf = ovf_o; o.cyc = cyc_n;
      obs_q.push_back(o);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = {$urandom(), 32'h8000_0000};
      4: begin
        v = 64'($urandom_range(0, 20));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic drive_random_op(input logic [TAG_W-1:0] tag);
    op_i   = 2'($urandom_range(0, 3));
    word_i = ($urandom_range(0, 2) == 0);
    op_a_i = rnd_operand();
    op_b_i = rnd_operand();
    tag_i  = tag;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    op_i = 2'b00; op_a_i = 64'd77; op_b_i = 64'd5; tag_i = 5'd3;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({in_ready_o, div_req_o, out_valid_o, dbz_o, ovf_o, err_o, tag_o,
         result_o, div_a_o, div_b_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b req=%b vld=%b err=%b res=%h a=%h b=%h required all zero",
               in_ready_o, div_req_o, out_valid_o, err_o, result_o, div_a_o, div_b_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_hold: in_ready=%b required 0", in_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: in_ready=%b required 1", in_ready_o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [10] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
    logic        t_w   [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [63:0] t_a   [10] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100,
                                64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000,
                                64'h8000_0000_0000_0000, 64'h1234_5678_8000_0000, 64'hFFFF_FFFE};
    logic [63:0] t_b   [10] = '{64'd2, 64'd2, 64'd7, 64'd7, 64'd0, 64'd0, '1, '1,
                                64'hFFFF_FFFF, 64'd1};
    logic [63:0] t_res [10] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd14, 64'd2, '1,
                                64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000, 64'd0,
                                64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFE};
    logic        t_dbz [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic        t_ovf [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    int unsigned guard = 0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1; op_i = t_op[i]; word_i = t_w[i];
      op_a_i = t_a[i]; op_b_i = t_b[i]; tag_i = 5'(i + 4);
      tick();
    end
    in_valid_i = 1'b0;
    while (obs_q.size() < 10 && guard < 60) begin tick(); guard++; end
    checks++;
    if (obs_q.size() != 10 || exp_q.size() != 10) begin
      errors++;
      $display("FAIL directed_count: results=%0d accepts=%0d required 10", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < 10 && i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].res !== t_res[i] || obs_q[i].dbz !== t_dbz[i] || obs_q[i].ovf !== t_ovf[i]
          || obs_q[i].tag !== 5'(i + 4)) begin
        errors++;
        $display("FAIL directed_%0d: res=%h dbz=%b ovf=%b tag=%0d required res=%h dbz=%b ovf=%b tag=%0d",
                 i, obs_q[i].res, obs_q[i].dbz, obs_q[i].ovf, obs_q[i].tag,
                 t_res[i], t_dbz[i], t_ovf[i], i + 4);
      end
      checks++;
      if (obs_q[i].cyc - exp_q[i].cyc != L + 1) begin
        errors++;
        $display("FAIL directed_latency_%0d: latency=%0d required %0d", i,
                 obs_q[i].cyc - exp_q[i].cyc, L + 1);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    int unsigned guard = 0;
    out_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      in_valid_i = 1'b1; drive_random_op(5'(i));
      tick();
    end
    checks++;
    if (exp_q.size() != DEPTH || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill: accepts=%0d in_ready=%b required %0d and 0", exp_q.size(), in_ready_o, DEPTH);
    end
    in_valid_i = 1'b0;
    repeat (L + 4) tick();
    out_ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL bp_steady_%0d: in_ready=%b out_valid=%b required 1 and 1", k, in_ready_o, out_valid_o);
        end
      end
      in_valid_i = 1'b1; drive_random_op(5'(k + 7));
      tick();
    end
    in_valid_i = 1'b0;
    while (obs_q.size() < exp_q.size() && guard < 200) begin tick(); guard++; end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_drain: results=%0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].res !== exp_q[i].res || obs_q[i].tag !== exp_q[i].tag ||
          obs_q[i].dbz !== exp_q[i].dbz || obs_q[i].ovf !== exp_q[i].ovf) begin
        errors++;
        $display("FAIL bp_item_%0d: res=%h tag=%0d dbz=%b ovf=%b required res=%h tag=%0d dbz=%b ovf=%b",
                 i, obs_q[i].res, obs_q[i].tag, obs_q[i].dbz, obs_q[i].ovf,
                 exp_q[i].res, exp_q[i].tag, exp_q[i].dbz, exp_q[i].ovf);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    int unsigned guard = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 7);
      drive_random_op(5'($urandom()));
      tick();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    while (obs_q.size() < exp_q.size() && guard < 200) begin tick(); guard++; end
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() < 50) begin
      errors++;
      $display("FAIL rand_count: results=%0d accepts=%0d required equal and >= 50", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].res !== exp_q[i].res || obs_q[i].tag !== exp_q[i].tag ||
          obs_q[i].dbz !== exp_q[i].dbz || obs_q[i].ovf !== exp_q[i].ovf) begin
        errors++;
        $display("FAIL rand_item_%0d: res=%h tag=%0d dbz=%b ovf=%b required res=%h tag=%0d dbz=%b ovf=%b",
                 i, obs_q[i].res, obs_q[i].tag, obs_q[i].dbz, obs_q[i].ovf,
                 exp_q[i].res, exp_q[i].tag, exp_q[i].dbz, exp_q[i].ovf);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_inflight();
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; drive_random_op(5'(i));
      tick();
    end
    in_valid_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 5 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL rst_inflight_setup: accepts=%0d results=%0d required 5 and 0", exp_q.size(), obs_q.size());
    end
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    exp_q.delete(); obs_q.delete();
    tick();
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_inflight_ready: in_ready=%b required 1", in_ready_o);
    end
    repeat (L + 10) tick();
    checks++;
    if (obs_q.size() != 0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight_stale: results=%0d out_valid=%b required 0 and 0", obs_q.size(), out_valid_o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_err();
    out_ready_i = 1'b1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_initial: err=%b required 0", err_o);
    end
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (10) tick();
    checks++;
    if (err_o !== 1'b1 || obs_q.size() != 0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: err=%b results=%0d out_valid=%b required 1, 0, 0", err_o, obs_q.size(), out_valid_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: err=%b required 0", err_o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
